// File: rtl/mux_scan_sequencer_if.sv
// Word-in / bit-out handshake bundle for the mux scan sequencer.
// The sequencer takes the slave side; the word source / bit sink take master.
interface mux_scan_sequencer_if;
    logic [7:0] wordIn;
    logic       wordValid;
    logic       wordReady;
    logic [7:0] dataIn;
    logic [2:0] selectLine;
    logic       bitValid;
    logic       bitReady;
    logic       firstBit;
    logic       lastBit;
    logic       busy;

    modport slave (
        input  wordIn, wordValid, bitReady,
        output wordReady, dataIn, selectLine,
        output bitValid, firstBit, lastBit, busy
    );

    modport master (
        output wordIn, wordValid, bitReady,
        input  wordReady, dataIn, selectLine,
        input  bitValid, firstBit, lastBit, busy
    );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Drives an 8:1 mux: holds a word on dataIn and walks selectLine
// through all eight bits under valid/ready flow control.
module mux_scan_sequencer #(
    parameter bit          MSB_FIRST  = 1'b0,
    parameter int unsigned GAP_CYCLES = 0
) (
    input logic clk,
    input logic rst,
    mux_scan_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } stateT;

    localparam logic [2:0] START = MSB_FIRST ? 3'd7 : 3'd0;
    localparam logic [2:0] END   = MSB_FIRST ? 3'd0 : 3'd7;
    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);
    localparam bit         HAS_GAP  = (GAP_CYCLES != 0);

    stateT      state;
    stateT      stateNext;
    logic [7:0] dataReg;
    logic [2:0] selReg;
    logic [3:0] gapCnt;

    logic wordReady;
    logic bitValid;
    logic firstBit;
    logic lastBit;
    logic busy;
    logic wordXfer;
    logic bitXfer;

    assign wordXfer = bus.wordValid && wordReady;
    assign bitXfer  = bitValid && bus.bitReady;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (wordXfer) stateNext = SHIFT;
            end
            SHIFT: begin
                if (bitXfer && lastBit) begin
                    if (HAS_GAP)       stateNext = GAP;
                    else if (wordXfer) stateNext = SHIFT;
                    else               stateNext = IDLE;
                end
            end
            GAP: begin
                if (gapCnt == 4'd0) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // wordReady in SHIFT is a combinational path from bitReady so a
    // new word can land on the same edge the last bit leaves.
    always_comb begin
        wordReady = 1'b0;
        bitValid  = 1'b0;
        firstBit  = 1'b0;
        lastBit   = 1'b0;
        busy      = (state != IDLE);
        unique case (state)
            IDLE: begin
                wordReady = !rst;
            end
            SHIFT: begin
                bitValid  = 1'b1;
                firstBit  = (selReg == START);
                lastBit   = (selReg == END);
                wordReady = !HAS_GAP && lastBit && bus.bitReady;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dataReg <= 8'h00;
            selReg  <= 3'd0;
        end else if (wordXfer) begin
            dataReg <= bus.wordIn;
            selReg  <= START;
        end else if (bitXfer && !lastBit) begin
            selReg  <= MSB_FIRST ? selReg - 3'd1 : selReg + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gapCnt <= 4'd0;
        end else if (HAS_GAP && bitXfer && lastBit) begin
            gapCnt <= GAP_LOAD;
        end else if (state == GAP && gapCnt != 4'd0) begin
            gapCnt <= gapCnt - 4'd1;
        end
    end

    assign bus.wordReady  = wordReady;
    assign bus.dataIn     = dataReg;
    assign bus.selectLine = selReg;
    assign bus.bitValid   = bitValid;
    assign bus.firstBit   = firstBit;
    assign bus.lastBit    = lastBit;
    assign bus.busy       = busy;
endmodule
